// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the fetch PC and drives the byte-addressed instruction memory over a
// single-outstanding req/ack handshake. Returned instructions go into a
// 2-entry FIFO (instruction + PC) that is presented to decode with
// valid/ready. Branch redirects flush the FIFO, reload the PC and, if a
// request is already in flight, discard its response when it arrives.
//
// Optional build macro: FETCH_PERF_CNT_EN
//    defined   : fetchCount counts FIFO pops (wraps at 2^32).
//    undefined : fetchCount is tied to 0 and no counter register exists.
//
// Ports
//    clk            rising-edge clock
//    rst_n          asynchronous active-low reset
//    fetchEn        permits new memory requests
//    redirectValid  one-cycle redirect strobe
//    redirectPc     redirect target (bits [1:0] are cleared on load)
//    memReq         read request, held until memAck
//    memAddr        request byte address, stable while memReq=1
//    memAck         response strobe, memRdata valid this cycle
//    memRdata       returned instruction
//    instValid      FIFO head valid
//    instReady      decode accepts the head
//    instData       head instruction
//    instPc         PC of the head instruction
//    fetchCount     accepted-instruction counter
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no request outstanding; waits for fetchEn and FIFO space
// REQ      | request to fetchPc outstanding; response is pushed on ack
// DISCARD  | redirected while a request was in flight; ack is dropped
// -----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int unsigned          dataWidth = 64,
   parameter int unsigned          instWidth = 32,
   parameter logic [dataWidth-1:0] resetPc   = '0,
   parameter int unsigned          pcStep    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 fetchEn,
   input  logic                 redirectValid,
   input  logic [dataWidth-1:0] redirectPc,
   output logic                 memReq,
   output logic [dataWidth-1:0] memAddr,
   input  logic                 memAck,
   input  logic [instWidth-1:0] memRdata,
   output logic                 instValid,
   input  logic                 instReady,
   output logic [instWidth-1:0] instData,
   output logic [dataWidth-1:0] instPc,
   output logic [31:0]          fetchCount
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [dataWidth-1:0] fetch_pc_q, fetch_pc_d;
   logic [dataWidth-1:0] mem_addr_q, mem_addr_d;
   logic                 mem_req_q, mem_req_d;

   logic [1:0]           count_q, count_d;
   logic                 inst_valid_q;
   logic [instWidth-1:0] head_data_q, head_data_d;
   logic [dataWidth-1:0] head_pc_q, head_pc_d;
   logic [instWidth-1:0] tail_data_q, tail_data_d;
   logic [dataWidth-1:0] tail_pc_q, tail_pc_d;

   logic                 flush;
   logic                 pop;
   logic                 push;
   logic [1:0]           occ_base;
   logic [dataWidth-1:0] redirect_pc_aligned;

   // Low address bits of the redirect target are discarded by design.
   logic                 unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirectPc[1:0];

   assign redirect_pc_aligned = {redirectPc[dataWidth-1:2], 2'b00};

   always_comb begin
      flush = redirectValid;
      // Flush wins over pop: the head is not consumed in a redirect cycle.
      pop   = inst_valid_q & instReady & ~flush;
      // Occupancy after this cycle's pop (or flush), before any push.
      occ_base = flush ? 2'd0 : (count_q - {1'b0, pop});

      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      push       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (flush) fetch_pc_d = redirect_pc_aligned;
            if (fetchEn && (occ_base < 2'd2)) state_d = S_REQ;
         end
         S_REQ: begin
            if (flush) begin
               fetch_pc_d = redirect_pc_aligned;
               state_d    = memAck ? S_IDLE : S_DISCARD;
            end else if (memAck) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + dataWidth'(pcStep);
               // Another request only if the FIFO still has room after this push.
               state_d    = (fetchEn && (occ_base == 2'd0)) ? S_REQ : S_IDLE;
            end
         end
         S_DISCARD: begin
            if (flush) fetch_pc_d = redirect_pc_aligned;
            if (memAck) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      mem_req_d  = (state_d != S_IDLE);
      // The stale address stays on the bus until the discarded ack arrives.
      mem_addr_d = (state_d == S_DISCARD) ? mem_addr_q : fetch_pc_d;
   end

   always_comb begin
      count_d     = count_q;
      head_data_d = head_data_q;
      head_pc_d   = head_pc_q;
      tail_data_d = tail_data_q;
      tail_pc_d   = tail_pc_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         case ({push, pop})
            2'b11: begin
               if (count_q == 2'd2) begin
                  head_data_d = tail_data_q;
                  head_pc_d   = tail_pc_q;
                  tail_data_d = memRdata;
                  tail_pc_d   = fetch_pc_q;
               end else begin
                  head_data_d = memRdata;
                  head_pc_d   = fetch_pc_q;
               end
            end
            2'b10: begin
               if (count_q == 2'd0) begin
                  head_data_d = memRdata;
                  head_pc_d   = fetch_pc_q;
                  count_d     = 2'd1;
               end else begin
                  tail_data_d = memRdata;
                  tail_pc_d   = fetch_pc_q;
                  count_d     = 2'd2;
               end
            end
            2'b01: begin
               head_data_d = tail_data_q;
               head_pc_d   = tail_pc_q;
               count_d     = count_q - 2'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         fetch_pc_q   <= resetPc;
         mem_addr_q   <= resetPc;
         mem_req_q    <= 1'b0;
         count_q      <= 2'd0;
         inst_valid_q <= 1'b0;
         head_data_q  <= '0;
         head_pc_q    <= '0;
         tail_data_q  <= '0;
         tail_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         mem_addr_q   <= mem_addr_d;
         mem_req_q    <= mem_req_d;
         count_q      <= count_d;
         inst_valid_q <= (count_d != 2'd0);
         head_data_q  <= head_data_d;
         head_pc_q    <= head_pc_d;
         tail_data_q  <= tail_data_d;
         tail_pc_q    <= tail_pc_d;
      end
   end

   assign memReq    = mem_req_q;
   assign memAddr   = mem_addr_q;
   assign instValid = inst_valid_q;
   assign instData  = head_data_q;
   assign instPc    = head_pc_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perf_cnt_q <= 32'd0;
      else if (pop) perf_cnt_q <= perf_cnt_q + 32'd1;
   end

   assign fetchCount = perf_cnt_q;
`else
   assign fetchCount = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetchEn = 1'b0;
   logic        redirectValid = 1'b0;
   logic [63:0] redirectPc = '0;
   logic        memReq;
   logic [63:0] memAddr;
   logic        memAck = 1'b0;
   logic [31:0] memRdata = '0;
   logic        instValid;
   logic        instReady = 1'b0;
   logic [31:0] instData;
   logic [63:0] instPc;
   logic [31:0] fetchCount;

   int tests = 0;
   int fails = 0;

   fetch_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fetchEn      (fetchEn),
      .redirectValid(redirectValid),
      .redirectPc   (redirectPc),
      .memReq       (memReq),
      .memAddr      (memAddr),
      .memAck       (memAck),
      .memRdata     (memRdata),
      .instValid    (instValid),
      .instReady    (instReady),
      .instData     (instData),
      .instPc       (instPc),
      .fetchCount   (fetchCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      fetchEn = 1'b0; redirectValid = 1'b0; redirectPc = '0;
      memAck = 1'b0; memRdata = '0; instReady = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_req();
      int n = 0;
      while (memReq !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (memReq !== 1'b1) check("wait_req_timeout", {63'd0, memReq}, 64'd1);
   endtask

   // Waits for the request, checks its address, acks one cycle later.
   task automatic do_fetch(input logic [63:0] exp_addr, input logic [31:0] data);
      wait_req();
      check("req_addr", memAddr, exp_addr);
      tick();
      memAck = 1'b1; memRdata = data;
      tick();
      memAck = 1'b0; memRdata = '0;
   endtask

   initial begin
      // ---------------- reset state ----------------
      #1;
      check("rst_memReq", {63'd0, memReq}, 64'd0);
      check("rst_memAddr", memAddr, 64'd0);
      check("rst_instValid", {63'd0, instValid}, 64'd0);
      check("rst_instData", {32'd0, instData}, 64'd0);
      check("rst_instPc", instPc, 64'd0);
      check("rst_fetchCount", {32'd0, fetchCount}, 64'd0);

      // ---------------- sequential fetch ----------------
      do_reset();
      instReady = 1'b1; fetchEn = 1'b1;
      tick();
      check("seq_req0", {63'd0, memReq}, 64'd1);
      check("seq_addr0", memAddr, 64'd0);
      tick();
      check("seq_novalid_before_ack", {63'd0, instValid}, 64'd0);
      memAck = 1'b1; memRdata = 32'hA000_0000;
      tick();
      memAck = 1'b0;
      check("seq_valid_latency", {63'd0, instValid}, 64'd1);
      check("seq_pc0", instPc, 64'd0);
      check("seq_data0", {32'd0, instData}, 64'h0000_0000_A000_0000);
      do_fetch(64'd4, 32'hA000_0004);
      check("seq_pc4", instPc, 64'd4);
      check("seq_data4", {32'd0, instData}, 64'h0000_0000_A000_0004);
      do_fetch(64'd8, 32'hA000_0008);
      check("seq_pc8", instPc, 64'd8);
      check("seq_data8", {32'd0, instData}, 64'h0000_0000_A000_0008);
      do_fetch(64'd12, 32'hA000_000C);
      check("seq_pc12", instPc, 64'd12);
      check("seq_data12", {32'd0, instData}, 64'h0000_0000_A000_000C);

      // ---------------- backpressure ----------------
      do_reset();
      instReady = 1'b0; fetchEn = 1'b1;
      do_fetch(64'd0, 32'hB000_0000);
      do_fetch(64'd4, 32'hB000_0004);
      tick(); tick(); tick();
      check("bp_memReq_low", {63'd0, memReq}, 64'd0);
      check("bp_memAddr_hold", memAddr, 64'd8);
      check("bp_valid", {63'd0, instValid}, 64'd1);
      check("bp_head_pc0", instPc, 64'd0);
      check("bp_head_data0", {32'd0, instData}, 64'h0000_0000_B000_0000);
      instReady = 1'b1;
      tick();
      check("bp_drain_pc4", instPc, 64'd4);
      check("bp_drain_data4", {32'd0, instData}, 64'h0000_0000_B000_0004);
      check("bp_resume_req", {63'd0, memReq}, 64'd1);
      check("bp_resume_addr", memAddr, 64'd8);
      tick();
      check("bp_empty", {63'd0, instValid}, 64'd0);
      do_fetch(64'd8, 32'hB000_0008);
      check("bp_pc8", instPc, 64'd8);

      // ---------------- redirect in flight ----------------
      do_reset();
      instReady = 1'b1; fetchEn = 1'b1;
      do_fetch(64'd0, 32'hC000_0000);
      do_fetch(64'd4, 32'hC000_0004);
      check("rdf_head_pc4", instPc, 64'd4);
      check("rdf_req8", memAddr, 64'd8);
      redirectValid = 1'b1; redirectPc = 64'h100;
      tick();
      redirectValid = 1'b0; redirectPc = '0;
      check("rdf_flushed", {63'd0, instValid}, 64'd0);
      check("rdf_req_held", {63'd0, memReq}, 64'd1);
      check("rdf_stale_addr", memAddr, 64'd8);
      tick(); tick();
      check("rdf_stale_addr_hold", memAddr, 64'd8);
      memAck = 1'b1; memRdata = 32'hDEAD_0008;
      tick();
      memAck = 1'b0; memRdata = '0;
      check("rdf_dropped", {63'd0, instValid}, 64'd0);
      check("rdf_idle", {63'd0, memReq}, 64'd0);
      tick();
      check("rdf_no_stale_data", {63'd0, instValid}, 64'd0);
      check("rdf_new_addr", memAddr, 64'h100);
      do_fetch(64'h100, 32'hC000_0100);
      check("rdf_pc100", instPc, 64'h100);
      check("rdf_data100", {32'd0, instData}, 64'h0000_0000_C000_0100);

      // ---------------- same-cycle redirect + ack ----------------
      do_reset();
      instReady = 1'b1; fetchEn = 1'b1;
      wait_req();
      check("sc_addr0", memAddr, 64'd0);
      tick();
      memAck = 1'b1; memRdata = 32'hEEEE_0000;
      redirectValid = 1'b1; redirectPc = 64'h203;
      tick();
      memAck = 1'b0; redirectValid = 1'b0; redirectPc = '0;
      check("sc_dropped", {63'd0, instValid}, 64'd0);
      check("sc_idle", {63'd0, memReq}, 64'd0);
      tick();
      check("sc_req", {63'd0, memReq}, 64'd1);
      check("sc_aligned_addr", memAddr, 64'h200);

      // ---------------- async reset mid-request ----------------
      do_reset();
      instReady = 1'b0; fetchEn = 1'b1;
      do_fetch(64'd0, 32'hF000_0000);
      tick();
      check("ar_pre_req", {63'd0, memReq}, 64'd1);
      check("ar_pre_valid", {63'd0, instValid}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_memReq", {63'd0, memReq}, 64'd0);
      check("ar_instValid", {63'd0, instValid}, 64'd0);
      check("ar_memAddr", memAddr, 64'd0);
      fetchEn = 1'b0;
      tick();
      rst_n = 1'b1;
      memAck = 1'b1; memRdata = 32'h1A7E_0000;
      tick();
      memAck = 1'b0; memRdata = '0;
      tick();
      check("ar_late_ack_valid", {63'd0, instValid}, 64'd0);
      check("ar_late_ack_req", {63'd0, memReq}, 64'd0);

      // ---------------- perf counter ----------------
      do_reset();
      instReady = 1'b1; fetchEn = 1'b1;
      do_fetch(64'd0, 32'h5000_0000);
      do_fetch(64'd4, 32'h5000_0004);
      tick();
      redirectValid = 1'b1; redirectPc = 64'h40;
      tick();
      redirectValid = 1'b0; redirectPc = '0;
      memAck = 1'b1;
      tick();
      memAck = 1'b0;
      do_fetch(64'h40, 32'h5000_0040);
      do_fetch(64'h44, 32'h5000_0044);
      do_fetch(64'h48, 32'h5000_0048);
      check("pc_last_pc48", instPc, 64'h48);
      tick();
      check("pc_drained", {63'd0, instValid}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
      check("pc_fetchCount", {32'd0, fetchCount}, 64'd5);
`else
      check("pc_fetchCount", {32'd0, fetchCount}, 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
